// File: rtl/pulse_peak_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_peak_detector_pkg
//  Description : Shared types and widths for the pulse peak detector:
//                filter sample width, FSM state encoding, event record.
//  Revision    : 1.0  initial release
// ============================================================================
package pulse_peak_detector_pkg;

    // Width of the signed shaped samples coming from the trapezoidal shaper.
    localparam int SIZE_FILTER_DATA = 16;

    // Widest timestamp an event record can carry; TS_WIDTH must not exceed it.
    localparam int PEAK_TS_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2
    } peak_state_t;

    // One detected pulse. The timestamp is zero-extended from TS_WIDTH.
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic [PEAK_TS_MAX-1:0]             tstamp;
        logic [7:0]                         width;
    } peak_event_t;

    // Increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_peak_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_peak_detector_if
//  Description : Event readout bus: valid/ready handshake carrying one pulse
//                record, plus the dropped-event counter.
//  Revision    : 1.0  initial release
// ============================================================================
interface pulse_peak_detector_if
    import pulse_peak_detector_pkg::*;
#(
    parameter int DATA_W = SIZE_FILTER_DATA,
    parameter int TS_W   = 32
);
    logic                     peak_valid;
    logic                     peak_ready;
    logic signed [DATA_W-1:0] peak_amp;
    logic [TS_W-1:0]          peak_time;
    logic [7:0]               peak_width;
    logic [15:0]              lost_count;

    modport master (
        output peak_valid,
        output peak_amp,
        output peak_time,
        output peak_width,
        output lost_count,
        input  peak_ready
    );

    modport slave (
        input  peak_valid,
        input  peak_amp,
        input  peak_time,
        input  peak_width,
        input  lost_count,
        output peak_ready
    );
endinterface
`default_nettype wire

// File: rtl/pulse_peak_detector_peak_event_reg.sv
`default_nettype none
// ============================================================================
//  Module      : peak_event_reg
//  Description : One-entry valid/ready holding register. A new record is
//                taken when the slot is empty or being drained this cycle;
//                otherwise it is dropped and a saturating loss count bumps.
//  Revision    : 1.0  initial release
// ============================================================================
module peak_event_reg
    import pulse_peak_detector_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        load_i,
    input  wire peak_event_t data_i,
    input  wire logic        ready_i,
    output logic             valid_o,
    output peak_event_t      data_o,
    output logic [15:0]      lost_count_o
);
    logic        valid_q, valid_d;
    peak_event_t data_q,  data_d;
    logic [15:0] lost_q,  lost_d;
    logic        accept;

    // Next-state: load/replace on a free slot, otherwise count the drop.
    always_comb begin
        accept  = valid_q & ready_i;
        valid_d = valid_q;
        data_d  = data_q;
        lost_d  = lost_q;
        if (load_i) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                data_d  = data_i;
            end else if (lost_q != 16'hFFFF) begin
                lost_d = lost_q + 16'd1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            lost_q  <= 16'd0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            lost_q  <= lost_d;
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign lost_count_o = lost_q;
endmodule
`default_nettype wire

// File: rtl/pulse_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_peak_detector
//  Description : Detects pulses rising strictly above THRESHOLD in the shaped
//                sample stream, captures peak amplitude, peak timestamp and
//                time-over-threshold, and presents one record per pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_peak_detector
    import pulse_peak_detector_pkg::*;
#(
    parameter logic signed [SIZE_FILTER_DATA-1:0] THRESHOLD = SIZE_FILTER_DATA'(100),
    parameter int unsigned                        HOLDOFF   = 4,
    parameter int unsigned                        TS_WIDTH  = 32
)(
    input  wire logic                               clk,
    input  wire logic                               reset,
    input  wire logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    pulse_peak_detector_if.master                   peak_if
);
    localparam logic [7:0] HOLDOFF_CNT = 8'(HOLDOFF);

    logic signed [SIZE_FILTER_DATA-1:0] sample_q;
    logic [TS_WIDTH-1:0]                ts_q;
    logic                               started_q;

    peak_state_t                        state_q;
    logic signed [SIZE_FILTER_DATA-1:0] max_q;
    logic [TS_WIDTH-1:0]                tmax_q;
    logic [7:0]                         width_q;
    logic [7:0]                         hold_q;
    logic                               emit_q;

    peak_event_t                        ev_data;
    peak_event_t                        held;
    logic                               held_valid;
    logic [15:0]                        held_lost;

    // Input stage: register the sample and tag it with its index. started_q
    // marks that sample_q/ts_q hold a real post-reset sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q  <= '0;
            ts_q      <= '0;
            started_q <= 1'b0;
        end else begin
            sample_q  <= filter_data;
            ts_q      <= started_q ? ts_q + 1'b1 : '0;
            started_q <= 1'b1;
        end
    end

    // Pulse FSM: track max/first-max time/width, emit a one-cycle strobe on
    // the terminating sample, then sit dead for HOLDOFF samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            max_q   <= '0;
            tmax_q  <= '0;
            width_q <= 8'd0;
            hold_q  <= 8'd0;
            emit_q  <= 1'b0;
        end else begin
            emit_q <= 1'b0;
            if (started_q) begin
                case (state_q)
                    IDLE: begin
                        if (sample_q > THRESHOLD) begin
                            state_q <= RISE;
                            max_q   <= sample_q;
                            tmax_q  <= ts_q;
                            width_q <= 8'd1;
                        end
                    end
                    RISE: begin
                        if (sample_q > THRESHOLD) begin
                            width_q <= sat_inc8(width_q);
                            if (sample_q > max_q) begin
                                max_q  <= sample_q;
                                tmax_q <= ts_q;
                            end
                        end else begin
                            emit_q <= 1'b1;
                            if (HOLDOFF_CNT == 8'd0) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= HOLD;
                                hold_q  <= HOLDOFF_CNT;
                            end
                        end
                    end
                    HOLD: begin
                        hold_q <= hold_q - 8'd1;
                        if (hold_q <= 8'd1) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ev_data.amp    = max_q;
    assign ev_data.tstamp = PEAK_TS_MAX'(tmax_q);
    assign ev_data.width  = width_q;

    peak_event_reg u_event_reg (
        .clk          (clk),
        .reset        (reset),
        .load_i       (emit_q),
        .data_i       (ev_data),
        .ready_i      (peak_if.peak_ready),
        .valid_o      (held_valid),
        .data_o       (held),
        .lost_count_o (held_lost)
    );

    assign peak_if.peak_valid = held_valid;
    assign peak_if.peak_amp   = held.amp;
    assign peak_if.peak_time  = held.tstamp[TS_WIDTH-1:0];
    assign peak_if.peak_width = held.width;
    assign peak_if.lost_count = held_lost;
endmodule
`default_nettype wire
